uart_msg_arbiter: RTL and testbench

Shares the single uart_tx transmitter among NUM_REQ status reporters, such as per-register result checkers. Each requester owns one fixed-length message slot in an external byte ROM. The block arbitrates round-robin and streams the granted message byte-by-byte into uart_tx using the tx_start/tx_busy handshake. It replaces ad-hoc message FSMs inside the core with one reusable scheduler.

---
 rtl/uart_msg_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_uart_msg_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: round-robin scheduler that streams fixed-length ROM messages into uart_tx.
// Optional CR/LF trailer after every message is enabled by defining UART_ARB_CRLF_EN.
module uart_msg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MSG_LEN = 18,
    parameter int ADDR_W  = 7,
    parameter int BUSY_TO = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy
);
    localparam int CNT_W = $clog2(MSG_LEN + 1);
    localparam int TO_W  = $clog2(BUSY_TO + 1);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_START   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_TAIL    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [GID_W-1:0]   r_ptr;
    logic [GID_W-1:0]   r_gid;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_busy;
    logic [NUM_REQ-1:0] r_done;

    logic               w_gnt_vld;
    logic [GID_W-1:0]   w_gnt_id;
    logic [GID_W-1:0]   w_idx;
    logic [ADDR_W-1:0]  w_base;
    logic               w_msg_end;
    logic               w_byte_sent;
    logic               w_in_tail;

`ifdef UART_ARB_CRLF_EN
    logic [1:0]         r_crlf_idx;
    logic               r_in_tail;
    assign w_in_tail = r_in_tail;
`else
    assign w_in_tail = 1'b0;
`endif

    // Round-robin grant: first requester at or above the pointer, with wrap.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx     = GID_W'((32'(r_ptr) + 32'(k)) % 32'(NUM_REQ));
            w_gnt_id  = (req[w_idx] && !w_gnt_vld) ? w_idx : w_gnt_id;
            w_gnt_vld = w_gnt_vld | req[w_idx];
        end
    end

    assign w_base      = ADDR_W'(32'(w_gnt_id) * 32'(MSG_LEN));
    assign w_msg_end   = (rom_data == 8'h00) || (r_byte_cnt == CNT_W'(MSG_LEN));
    // A silent uart_tx (busy never rises) is treated as having taken the byte.
    assign w_byte_sent = ((r_state == S_WAIT_HI) && !tx_busy && (r_to_cnt == TO_W'(BUSY_TO - 1))) ||
                         ((r_state == S_WAIT_LO) && !tx_busy);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_gnt_vld ? S_FETCH : S_IDLE;
            S_FETCH:   w_next = w_msg_end ? S_TAIL : S_START;
            S_START:   w_next = tx_busy ? S_START : S_WAIT_HI;
            S_WAIT_HI: begin
                if (tx_busy) begin
                    w_next = S_WAIT_LO;
                end else if (w_byte_sent) begin
                    w_next = w_in_tail ? S_TAIL : S_FETCH;
                end else begin
                    w_next = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (w_byte_sent) begin
                    w_next = w_in_tail ? S_TAIL : S_FETCH;
                end else begin
                    w_next = S_WAIT_LO;
                end
            end
`ifdef UART_ARB_CRLF_EN
            S_TAIL:    w_next = (r_crlf_idx == 2'd2) ? S_DONE : S_START;
`else
            S_TAIL:    w_next = S_DONE;
`endif
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_gid      <= '0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
            r_rom_addr <= '0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= '0;
`ifdef UART_ARB_CRLF_EN
            r_crlf_idx <= 2'd0;
            r_in_tail  <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gid      <= w_gnt_id;
                        r_byte_cnt <= '0;
                        r_rom_addr <= w_base;
                        r_busy     <= 1'b1;
`ifdef UART_ARB_CRLF_EN
                        r_crlf_idx <= 2'd0;
                        r_in_tail  <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (!w_msg_end) begin
                        r_tx_data <= rom_data;
                    end
                end
                S_START: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_to_cnt   <= '0;
                    end
                end
                S_WAIT_HI, S_WAIT_LO: begin
                    if (r_state == S_WAIT_HI) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                    if (w_byte_sent && !w_in_tail) begin
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    end
                end
                S_TAIL: begin
`ifdef UART_ARB_CRLF_EN
                    r_in_tail <= 1'b1;
                    case (r_crlf_idx)
                        2'd0:    r_tx_data <= 8'h0D;
                        2'd1:    r_tx_data <= 8'h0A;
                        default: r_tx_data <= r_tx_data;
                    endcase
                    if (r_crlf_idx != 2'd2) begin
                        r_crlf_idx <= r_crlf_idx + 2'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_done <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gid;
                    r_busy <= 1'b0;
                    r_ptr  <= (r_gid == GID_W'(NUM_REQ - 1)) ? '0 : r_gid + GID_W'(1);
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign done     = r_done;
    assign busy     = r_busy;
    assign rom_addr = r_rom_addr;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed testbench for uart_msg_arbiter with a combinational ROM and a simple uart_tx model.
module tb_uart_msg_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic       busy;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic [7:0] rom [0:127];
    logic       uart_en;
    int         m_cnt = 0;
    int         cyc = 0;

    logic [7:0] q_data [$];
    int         start_cyc [$];
    int         done_order [$];
    int         start_total = 0;
    int         done_total = 0;
    int         viol = 0;
    int         done_cnt [4] = '{0, 0, 0, 0};
    logic [6:0] last_busy_addr = 7'd0;

    int         errors = 0;
    int         checks = 0;

    uart_msg_arbiter #(.NUM_REQ(4), .MSG_LEN(18), .ADDR_W(7), .BUSY_TO(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .busy(busy),
        .rom_addr(rom_addr), .rom_data(rom_data), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy)
    );

    assign rom_data = rom[rom_addr];
    // uart model: busy rises one cycle after the start strobe and stays high 10 cycles
    assign tx_busy  = uart_en && (m_cnt >= 1) && (m_cnt <= 10);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) m_cnt <= 11;
        else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                q_data.push_back(tx_data);
                start_cyc.push_back(cyc);
                start_total <= start_total + 1;
                if (tx_busy) viol <= viol + 1;
            end
            for (int i = 0; i < 4; i++) begin
                if (done[i]) begin
                    done_order.push_back(i);
                    done_cnt[i] <= done_cnt[i] + 1;
                end
            end
            done_total <= done_total + $countones(done);
            if (busy) last_busy_addr <= rom_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int base, input logic [7:0] e [$]);
        chk({tag, "_len"}, 32'(q_data.size() - base), 32'(e.size()));
        foreach (e[i]) chk(tag, {24'h0, q_data[base + i]}, {24'h0, e[i]});
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_total < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        chk(tag, (done_total >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int n = 0;
        while (start_total < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        chk(tag, (start_total >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk); #1; n++;
        end
        chk(tag, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp [$];
        int sb;
        int db;
        int g0;

        for (int a = 0; a < 128; a++) rom[a] = 8'hEE;
        rom[0] = 8'h4D; rom[1] = 8'h55; rom[2] = 8'h4C; rom[3] = 8'h0A; rom[4] = 8'h00;
        rom[18] = 8'h00;
        rom[36] = 8'h41; rom[37] = 8'h42; rom[38] = 8'h00;
        for (int a = 0; a < 18; a++) rom[54 + a] = 8'(8'h30 + a);
        rom[72] = 8'h5A;

        uart_en = 1'b1;
        req     = 4'b0000;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {28'h0, done}, 32'd0);
        chk("rst_tx_start", {31'h0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
        chk("rst_rom_addr", {25'h0, rom_addr}, 32'd0);
        rst_n = 1'b1;

        // T1: single "MUL\n" message, latency of the first start strobe
        @(negedge clk);
        sb = start_total; db = done_total; g0 = done_cnt[0];
        req = 4'b0001;
        @(negedge clk); req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("t1_first_start", {31'h0, tx_start}, 32'd1);
        chk("t1_first_data", {24'h0, tx_data}, 32'h4D);
        chk("t1_busy", {31'h0, busy}, 32'd1);
        chk("t1_addr", {25'h0, rom_addr}, 32'd0);
        wait_done("t1_done_wait", db + 1, 1000);
        exp = '{8'h4D, 8'h55, 8'h4C, 8'h0A};
`ifdef UART_ARB_CRLF_EN
        exp.push_back(8'h0D); exp.push_back(8'h0A);
`endif
        check_seq("t1_seq", sb, exp);
        chk("t1_done0_cnt", 32'(done_cnt[0] - g0), 32'd1);
        chk("t1_busy_after", {31'h0, busy}, 32'd0);
        @(negedge clk);
        chk("t1_done_one_cycle", {28'h0, done}, 32'd0);

        // T4a: empty slot 1, no bytes sent, done in cycle N+3
        sb = start_total; db = done_total;
        req = 4'b0010;
        @(negedge clk); req = 4'b0000;
`ifdef UART_ARB_CRLF_EN
        wait_done("t4e_done_wait", db + 1, 500);
        chk("t4e_starts", 32'(start_total - sb), 32'd2);
`else
        @(negedge clk);
        chk("t4e_done_n1", {28'h0, done}, 32'd0);
        @(negedge clk);
        chk("t4e_done_n2", {28'h0, done}, 32'd0);
        @(negedge clk);
        chk("t4e_done_n3", {28'h0, done}, 32'b0010);
        #1;
        chk("t4e_starts", 32'(start_total - sb), 32'd0);
`endif

        // T4b: unterminated slot 3 sends exactly MSG_LEN bytes
        @(negedge clk);
        sb = start_total; db = done_total;
        req = 4'b1000;
        @(negedge clk); req = 4'b0000;
        wait_done("t4_done_wait", db + 1, 3000);
        exp.delete();
        for (int a = 0; a < 18; a++) exp.push_back(8'(8'h30 + a));
`ifdef UART_ARB_CRLF_EN
        exp.push_back(8'h0D); exp.push_back(8'h0A);
`endif
        check_seq("t4_seq", sb, exp);
        chk("t4_last_addr", {25'h0, last_busy_addr}, 32'd72);

        // T2: all requests held from reset release, order 0,1,2,3 twice
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        #1;
        db = done_order.size();
        g0 = done_total;
        rst_n = 1'b1;
        wait_done("t2_done_wait", g0 + 8, 6000);
        req = 4'b0000;
        wait_idle("t2_idle", 2000);
        for (int i = 0; i < 8; i++) chk("t2_order", 32'(done_order[db + i]), 32'(i % 4));

        // T3: pointer advance puts a late requester ahead of a repeat
        @(negedge clk);
        db = done_order.size(); g0 = done_total; sb = start_total;
        req = 4'b0100;
        wait_starts("t3_start_wait", sb + 1, 200);
        req = 4'b0110;
        wait_done("t3_done_wait", g0 + 2, 2000);
        req = 4'b0000;
        wait_idle("t3_idle", 2000);
        chk("t3_first", 32'(done_order[db]), 32'd2);
        chk("t3_second", 32'(done_order[db + 1]), 32'd1);

        // T5: uart busy never rises, every byte released by the timeout
        @(negedge clk);
        uart_en = 1'b0;
        sb = start_total; db = done_total;
        req = 4'b0001;
        @(negedge clk); req = 4'b0000;
        wait_done("t5_done_wait", db + 1, 2000);
        exp = '{8'h4D, 8'h55, 8'h4C, 8'h0A};
`ifdef UART_ARB_CRLF_EN
        exp.push_back(8'h0D); exp.push_back(8'h0A);
`endif
        check_seq("t5_seq", sb, exp);
        chk("t5_gap", 32'(start_cyc[sb + 1] - start_cyc[sb]), 32'd17);

        // T6: reset in the middle of the second byte, then a clean restart
        @(negedge clk);
        uart_en = 1'b1;
        sb = start_total; db = done_total; g0 = done_cnt[0];
        req = 4'b0001;
        wait_starts("t6_second_byte", sb + 2, 400);
        repeat (3) @(negedge clk);
        chk("t6_pre_addr", {25'h0, rom_addr}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_start", {31'h0, tx_start}, 32'd0);
        chk("t6_rst_busy", {31'h0, busy}, 32'd0);
        chk("t6_rst_done", {28'h0, done}, 32'd0);
        chk("t6_rst_addr", {25'h0, rom_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb = start_total;
        wait_starts("t6_restart", sb + 1, 400);
        req = 4'b0000;
        wait_done("t6_done_wait", db + 1, 1000);
        exp = '{8'h4D, 8'h55, 8'h4C, 8'h0A};
`ifdef UART_ARB_CRLF_EN
        exp.push_back(8'h0D); exp.push_back(8'h0A);
`endif
        check_seq("t6_seq", sb, exp);
        chk("t6_done0_cnt", 32'(done_cnt[0] - g0), 32'd1);

        @(negedge clk);
        chk("no_start_while_busy", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
